// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small received-byte FIFO.
// The serial line is synchronized and sampled at mid-bit. Good bytes are pushed
// into the FIFO; bad stop bits and drops caused by a full FIFO are each flagged
// with a one-cycle pulse.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  output logic                          rx_valid,
  output logic [7:0]                    rx_data,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] BIT_END  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(CLK_DIV / 2 - 1);

  logic          sync1_reg;
  logic          sync2_reg;     // synchronized line value (rxs)
  logic [1:0]    line_ok_reg;   // set once sync2_reg holds a real line sample
  logic          rxs_prev_reg;
  logic [1:0]    state_reg;
  logic [15:0]   timer_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          frame_err_reg;
  logic          overflow_reg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic          push_req;
  logic          pop;
  logic          full;
  logic          push_ok;

  // Two-flop synchronizer. The previous-value flop only records real samples,
  // so a line that is already low when reset ends is not seen as a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      line_ok_reg  <= 2'b00;
      rxs_prev_reg <= 1'b0;
    end else begin
      sync1_reg    <= uart_rx;
      sync2_reg    <= sync1_reg;
      line_ok_reg  <= {line_ok_reg[0], 1'b1};
      rxs_prev_reg <= line_ok_reg[1] & sync2_reg;
    end
  end

  // Receive FSM: detect start, confirm it at half a bit, then sample each
  // data bit and the stop bit one full bit period apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          timer_reg   <= '0;
          bit_idx_reg <= '0;
          if (rxs_prev_reg && !sync2_reg) state_reg <= START;
        end
        START: begin
          if (timer_reg == HALF_END) begin
            timer_reg <= '0;
            state_reg <= sync2_reg ? IDLE : DATA;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        DATA: begin
          if (timer_reg == BIT_END) begin
            timer_reg              <= '0;
            shift_reg[bit_idx_reg] <= sync2_reg;
            if (bit_idx_reg == 3'd7) state_reg <= STOP;
            else bit_idx_reg <= bit_idx_reg + 3'd1;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        STOP: begin
          if (timer_reg == BIT_END) begin
            timer_reg <= '0;
            state_reg <= IDLE;
            if (!sync2_reg) frame_err_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign push_req = (state_reg == STOP) && (timer_reg == BIT_END) && sync2_reg;
  assign pop      = (count_reg != '0) && rx_ready;
  assign full     = (count_reg == (AW+1)'(FIFO_DEPTH));
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  // FIFO storage write; no reset so the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= shift_reg;
  end

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= push_req && !push_ok;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rx_valid  = (count_reg != '0);
  assign rx_data   = rx_valid ? mem[rd_ptr_reg] : 8'h00;
  assign rx_count  = count_reg;
  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (CLK_DIV=16, FIFO_DEPTH=4). Expected bytes are
// queued as frames are sent and checked as the DUT hands them out.
module tb_uart_rx_fifo;
  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overflow;

  int tests_run    = 0;
  int tests_failed = 0;
  int fe_cnt  = 0;
  int ovf_cnt = 0;
  int fe0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_count(rx_count), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    wait_clks(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(CLK_DIV);
    end
    uart_rx = stop_bit;
    wait_clks(CLK_DIV);
    uart_rx = 1'b1;
    wait_clks(2 * CLK_DIV);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) wait_clks(1);
    rx_ready = 1'b0;
    wait_clks(1);
    chk("drain_empty", exp_q.size(), 0);
    chk("count_after_drain", rx_count, 0);
  endtask

  // Output monitor: pulse counters and scoreboard pops.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", exp_q.size(), 1);
      else chk("pop_data", rx_data, exp_q.pop_front());
    end
  end

  initial begin
    // Reset values
    wait_clks(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    wait_clks(5);

    // Single byte held in the FIFO
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    chk("a5_valid", rx_valid, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_count", rx_count, 1);
    drain();

    // Short low glitch must be rejected
    uart_rx = 1'b0;
    wait_clks(4);
    uart_rx = 1'b1;
    wait_clks(40);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", fe_cnt, 0);

    // Framing error then a good frame
    fe0 = fe_cnt;
    send_byte(8'h3C, 1'b0);
    chk("ferr_pulses", fe_cnt, fe0 + 1);
    chk("ferr_count", rx_count, 0);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    chk("after_ferr_count", rx_count, 1);
    chk("after_ferr_pulses", fe_cnt, fe0 + 1);
    drain();

    // Five bytes into a four-entry FIFO
    for (int b = 1; b <= 5; b++) begin
      if (b <= FIFO_DEPTH) exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1);
      chk($sformatf("fill_count_%0d", b), rx_count, (b > FIFO_DEPTH) ? FIFO_DEPTH : b);
      chk($sformatf("fill_ovf_%0d", b), ovf_cnt, (b > FIFO_DEPTH) ? 1 : 0);
    end

    // Full FIFO with a pop at the stop sample of byte 06
    exp_q.push_back(8'h06);
    fork
      send_byte(8'h06, 1'b1);
      begin
        wait_clks(154);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
      end
    join
    chk("simul_ovf", ovf_cnt, 1);
    chk("simul_count", rx_count, FIFO_DEPTH);
    drain();

    // Reset in the middle of a data bit
    fe0 = fe_cnt;
    fork
      send_byte(8'hF0, 1'b1);
      begin
        wait_clks(60);
        rst_n = 1'b0;
        wait_clks(2);
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_count", rx_count, 0);
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_ferr", frame_err, 0);
        chk("midrst_ovf", overflow, 0);
        rst_n = 1'b1;
      end
    join
    chk("post_rst_valid", rx_valid, 0);
    chk("post_rst_ferr", fe_cnt, fe0);
    chk("post_rst_ovf", ovf_cnt, 1);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    chk("c3_count", rx_count, 1);
    chk("c3_data", rx_data, 8'hC3);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
